// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: M-stage CP0 exception/interrupt controller for the P7 MIPS core.
// Arbitrates hardware interrupts against synchronous exceptions, raises the
// flush/redirect request, and owns SR, Cause, EPC and PRId. Fetch redirects to
// HANDLER_PC whenever req is high and to epc_out while an eret sits in M.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic        we_m,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rdata,
  output logic        req,
  output logic [31:0] epc_out,
  output logic        exl_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Architectural state, kept as the live fields only.
  logic [5:0]  sr_im_q,    sr_im_d;
  logic        sr_exl_q,   sr_exl_d;
  logic        sr_ie_q,    sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,      epc_d;
  logic        int_pend_q, int_pend_d;

  logic        int_hit;
  logic        int_cond;
  logic        int_take;
  logic        exc_take;
  logic        req_int;
  logic        mtc0_en;
  logic        eret_en;
  logic [31:0] epc_target;

  // Arbitration: the interrupt and exception take conditions, and the request
  // they raise. A latched pending interrupt counts as a live line so a pulse
  // seen only during bubbles is still serviced. Nothing is taken in reset.
  always_comb begin
    int_hit    = |(hw_int & sr_im_q);
    int_cond   = int_hit & sr_ie_q & ~sr_exl_q;
    int_take   = valid_m & sr_ie_q & ~sr_exl_q & (int_hit | int_pend_q) & ~reset;
    exc_take   = valid_m & ~sr_exl_q & (exc_code_m != 5'd0) & ~reset;
    req_int    = int_take | exc_take;
    mtc0_en    = we_m & valid_m & ~req_int;
    eret_en    = eret_m & valid_m & ~req_int;
    epc_target = (bd_m ? (pc_m - 32'd4) : pc_m) & 32'hFFFF_FFFC;
  end

  // Next-state for all CP0 registers: a request overrides mtc0 and eret, and
  // Cause.IP tracks the interrupt lines on every edge.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    int_pend_d  = int_pend_q;

    if (req_int) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_m;
      cause_exc_d = int_take ? 5'd0 : exc_code_m;
      epc_d       = epc_target;
    end else begin
      if (mtc0_en) begin
        case (cp0_addr)
          ADDR_SR: begin
            sr_im_d  = cp0_wdata[15:10];
            sr_exl_d = cp0_wdata[1];
            sr_ie_d  = cp0_wdata[0];
          end
          ADDR_EPC: epc_d = cp0_wdata & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      if (eret_en) begin
        sr_exl_d = 1'b0;
      end
    end

    if (req_int || !sr_ie_q || sr_exl_q) begin
      int_pend_d = 1'b0;
    end else if (int_cond && !valid_m) begin
      int_pend_d = 1'b1;
    end
  end

  // State register; reset clears everything immediately, including EXL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
      int_pend_q  <= 1'b0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
      int_pend_q  <= int_pend_d;
    end
  end

  // mfc0 read mux: pre-edge register values, unused bits read as zero.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      ADDR_CAUSE: cp0_rdata = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign req     = req_int;
  assign epc_out = epc_q;
  assign exl_out = sr_exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed test-plan scenarios plus random traffic, checked
// through a scoreboard queue against a word-level CP0 reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h2023_0007;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        we_m;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic        req;
  logic [31:0] epc_out;
  logic        exl_out;

  typedef struct {
    logic        req;
    logic [31:0] epc;
    logic        exl;
    logic [31:0] rd;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state as whole 32-bit register images.
  logic [31:0] mSr, mCause, mEpc;
  logic        mPend;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
    .exc_code_m(exc_code_m), .eret_m(eret_m), .we_m(we_m), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .hw_int(hw_int), .cp0_rdata(cp0_rdata), .req(req),
    .epc_out(epc_out), .exl_out(exl_out)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Predict this cycle's outputs from model state and current inputs.
  function automatic exp_t modelOutputs();
    exp_t e;
    logic ie, exl, hit, itake, etake;
    e.tag = 0;
    if (reset) begin
      e.req = 1'b0; e.epc = 32'd0; e.exl = 1'b0;
      e.rd  = (cp0_addr == 5'd15) ? PRID : 32'd0;
      return e;
    end
    ie    = mSr[0];
    exl   = mSr[1];
    hit   = |(hw_int & mSr[15:10]);
    itake = valid_m && ie && !exl && (hit || mPend);
    etake = valid_m && !exl && (exc_code_m != 5'd0);
    e.req = itake || etake;
    e.epc = mEpc;
    e.exl = exl;
    case (cp0_addr)
      5'd12:   e.rd = mSr;
      5'd13:   e.rd = mCause;
      5'd14:   e.rd = mEpc;
      5'd15:   e.rd = PRID;
      default: e.rd = 32'd0;
    endcase
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs held at that edge.
  task automatic modelStep();
    exp_t e;
    logic ie, exl, hit, itake, intc, newPend;
    logic [4:0] code;
    if (reset) begin
      mSr = 0; mCause = 0; mEpc = 0; mPend = 0;
      return;
    end
    e     = modelOutputs();
    ie    = mSr[0];
    exl   = mSr[1];
    hit   = |(hw_int & mSr[15:10]);
    itake = valid_m && ie && !exl && (hit || mPend);
    intc  = hit && ie && !exl;
    newPend = mPend;
    if (e.req || !ie || exl) newPend = 1'b0;
    else if (intc && !valid_m) newPend = 1'b1;
    if (e.req) begin
      code   = itake ? 5'd0 : exc_code_m;
      mSr    = mSr | 32'h2;
      mCause = (bd_m ? 32'h8000_0000 : 32'h0) | ({27'd0, code} << 2);
      mEpc   = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
    end else begin
      if (we_m && valid_m) begin
        if (cp0_addr == 5'd12) mSr = cp0_wdata & 32'h0000_FC03;
        if (cp0_addr == 5'd14) mEpc = cp0_wdata & 32'hFFFF_FFFC;
      end
      if (eret_m && valid_m) mSr = mSr & ~32'h2;
    end
    mCause = (mCause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
    mPend  = newPend;
  endtask

  task automatic clearInputs();
    valid_m = 0; pc_m = 0; bd_m = 0; exc_code_m = 0; eret_m = 0;
    we_m = 0; cp0_addr = 0; cp0_wdata = 0; hw_int = 0;
  endtask

  // Issue one cycle: push the expected response, then cross the edge.
  task automatic applyStimulus(input bit useConst, input logic [31:0] constRd, input int tag);
    exp_t e;
    e = modelOutputs();
    if (useConst) e.rd = constRd;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    modelStep();
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (req !== e.req) begin
      bad++; $display("FAIL req tag=%0d got=%0b want=%0b", e.tag, req, e.req);
    end
    total++;
    if (epc_out !== e.epc) begin
      bad++; $display("FAIL epc_out tag=%0d got=%h want=%h", e.tag, epc_out, e.epc);
    end
    total++;
    if (exl_out !== e.exl) begin
      bad++; $display("FAIL exl_out tag=%0d got=%0b want=%0b", e.tag, exl_out, e.exl);
    end
    total++;
    if (cp0_rdata !== e.rd) begin
      bad++; $display("FAIL cp0_rdata tag=%0d got=%h want=%h", e.tag, cp0_rdata, e.rd);
    end
  endtask

  // Monitor: compares DUT outputs against each queued expectation mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) checkOutput(sb.pop_front());
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  // Stimulus: test-plan scenarios, random traffic, then async reset mid-handler.
  initial begin
    logic [4:0] addrTab [6];
    int r;
    addrTab[0] = 5'd12; addrTab[1] = 5'd13; addrTab[2] = 5'd14;
    addrTab[3] = 5'd15; addrTab[4] = 5'd0;  addrTab[5] = 5'd9;
    mSr = 0; mCause = 0; mEpc = 0; mPend = 0;
    reset = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    cp0_addr = 5'd12; applyStimulus(1, 32'h0, 1);
    cp0_addr = 5'd15; applyStimulus(1, PRID, 2);

    // SR = IM0 | IE, then syscall
    valid_m = 1; we_m = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; applyStimulus(0, 0, 3);
    valid_m = 1; pc_m = 32'h0000_3008; exc_code_m = 5'd8; applyStimulus(0, 0, 4);
    cp0_addr = 5'd14; applyStimulus(1, 32'h0000_3008, 5);
    cp0_addr = 5'd13; applyStimulus(1, 32'h0000_0020, 6);
    valid_m = 1; eret_m = 1; applyStimulus(0, 0, 7);

    // Delay-slot trap, then a break ignored under EXL
    valid_m = 1; bd_m = 1; pc_m = 32'h0000_3010; exc_code_m = 5'd13; applyStimulus(0, 0, 8);
    valid_m = 1; exc_code_m = 5'd9; pc_m = 32'h0000_3100; cp0_addr = 5'd14;
    applyStimulus(1, 32'h0000_300C, 9);
    cp0_addr = 5'd13; applyStimulus(1, 32'h8000_0034, 10);
    valid_m = 1; eret_m = 1; applyStimulus(0, 0, 11);

    // Interrupt beats a simultaneous break
    valid_m = 1; hw_int = 6'b000001; exc_code_m = 5'd9; pc_m = 32'h0000_3018; applyStimulus(0, 0, 12);
    cp0_addr = 5'd13; applyStimulus(1, 32'h0000_0400, 13);
    valid_m = 1; eret_m = 1; applyStimulus(0, 0, 14);

    // Interrupt pulse during bubbles, taken at the next real instruction
    hw_int = 6'b000001; applyStimulus(0, 0, 15);
    applyStimulus(0, 0, 16);
    applyStimulus(0, 0, 17);
    valid_m = 1; pc_m = 32'h0000_3020; applyStimulus(0, 0, 18);
    cp0_addr = 5'd14; applyStimulus(1, 32'h0000_3020, 19);
    valid_m = 1; eret_m = 1; applyStimulus(0, 0, 20);

    // mtc0 EPC then eret; then mtc0 coincident with req is dropped
    valid_m = 1; we_m = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3044; applyStimulus(0, 0, 21);
    valid_m = 1; eret_m = 1; cp0_addr = 5'd14; applyStimulus(1, 32'h0000_3044, 22);
    cp0_addr = 5'd12; applyStimulus(1, 32'h0000_0401, 23);
    valid_m = 1; exc_code_m = 5'd8; pc_m = 32'h0000_3050; we_m = 1; cp0_addr = 5'd14;
    cp0_wdata = 32'hDEAD_BEEF; applyStimulus(0, 0, 24);
    cp0_addr = 5'd14; applyStimulus(1, 32'h0000_3050, 25);
    valid_m = 1; eret_m = 1; applyStimulus(0, 0, 26);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      valid_m    = ($urandom_range(0, 3) != 0);
      pc_m       = $urandom;
      bd_m       = 1'($urandom_range(0, 1));
      r          = $urandom_range(0, 9);
      exc_code_m = (r == 0) ? 5'd8 : (r == 1) ? 5'd9 : (r == 2) ? 5'd13 : 5'd0;
      eret_m     = ($urandom_range(0, 5) == 0);
      we_m       = ($urandom_range(0, 4) == 0);
      cp0_addr   = addrTab[$urandom_range(0, 5)];
      cp0_wdata  = $urandom;
      if (cp0_addr == 5'd12 && $urandom_range(0, 1) == 1) cp0_wdata[1:0] = 2'b01;
      hw_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      applyStimulus(0, 0, 100);
    end

    // Quiesce, take a syscall at 0x3000, then reset mid-handler
    valid_m = 1; we_m = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0; applyStimulus(0, 0, 200);
    valid_m = 1; we_m = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0; applyStimulus(0, 0, 201);
    valid_m = 1; pc_m = 32'h0000_3000; exc_code_m = 5'd8; applyStimulus(0, 0, 202);
    cp0_addr = 5'd14; applyStimulus(1, 32'h0000_3000, 203);
    reset = 1'b1; valid_m = 1; exc_code_m = 5'd8; cp0_addr = 5'd15;
    applyStimulus(1, PRID, 204);
    valid_m = 1; exc_code_m = 5'd9; cp0_addr = 5'd14; applyStimulus(1, 32'h0, 205);
    #1 reset = 1'b0;
    cp0_addr = 5'd13; applyStimulus(0, 0, 206);

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception and interrupt controller for the P7 pipelined MIPS core. It sits at the M stage and consumes the per-instruction 5-bit exception code produced by upstream exception detection (syscall 8, break 9, trap 13, 0 = none), together with external hardware interrupts. It arbitrates between interrupts and exceptions, raises the pipeline flush/redirect request, and holds the SR, Cause, EPC and PRId registers. It also services mtc0, mfc0 and eret.

## Interface
- HANDLER_PC, 32'h0000_4180: redirect target on any accepted exception or interrupt.
- PRID_VAL, 32'h2023_0007: constant returned for PRId reads.
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- valid_m  in  1  M stage holds a real instruction; low means bubble.
- pc_m  in  32  PC of the M-stage instruction.
- bd_m  in  1  M-stage instruction sits in a branch delay slot.
- exc_code_m  in  5  exception code of the M-stage instruction; 0 means none.
- eret_m  in  1  M-stage instruction is eret.
- we_m  in  1  M-stage instruction is mtc0.
- cp0_addr  in  5  CP0 register number for mtc0/mfc0.
- cp0_wdata  in  32  mtc0 write data.
- hw_int  in  6  level-sensitive external interrupt lines.
- cp0_rdata  out  32  mfc0 read data (combinational).
- req  out  1  flush the pipeline and redirect fetch to HANDLER_PC (combinational).
- epc_out  out  32  eret target; equals the EPC register.
- exl_out  out  1  current SR.EXL.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0. Cause is read-only.
  - EPC (14): full 32 bits. Bits [1:0] are forced to 0 on every write.
  - PRId (15): PRID_VAL.
  - Any other address reads 32'h0. Writes to addresses other than 12 and 14 are ignored.
- Cause.IP is loaded from hw_int every cycle, regardless of EXL.
- int_take = |(hw_int & SR.IM) & SR.IE & ~SR.EXL & valid_m.
- exc_take = (exc_code_m != 0) & ~SR.EXL & valid_m.
- req = int_take | exc_take. Interrupt has priority over exception.
- On req (next edge):
  - SR.EXL <= 1.
  - Cause.BD <= bd_m.
  - Cause.ExcCode <= int_take ? 0 : exc_code_m.
  - EPC <= bd_m ? pc_m-4 : pc_m, with bits [1:0] cleared and 32-bit wrap-around.
- Pending latch:
  - If the interrupt condition holds while valid_m = 0, set int_pend.
  - int_take also fires when int_pend=1, the first time valid_m=1 and SR.IE=1 and SR.EXL=0, even if hw_int has already dropped.
  - int_pend clears on any req, or when SR.IE=0 or SR.EXL=1.
- eret_m & valid_m & ~req clears SR.EXL on the next edge. epc_out is already valid in that cycle for fetch redirect.
- mtc0: when we_m & valid_m & ~req, write at the edge. A write to SR updates IM, EXL and IE only.
- Simultaneous events in one cycle:
  - req wins over mtc0 and eret in the same cycle; the mtc0 write and the EXL clear are both suppressed.
  - mtc0 to EPC in the cycle before eret: epc_out reflects the new value in the eret cycle.
- While SR.EXL=1, no further exceptions or interrupts are taken; exc_code_m is ignored.

## Timing
- Reset (asynchronous):
  - SR, Cause, EPC and int_pend all 0.
  - req=0, exl_out=0, epc_out=0.
  - cp0_rdata is 0 for every address except 15.
- Latency:
  - req is combinational, in the same cycle the offending instruction is in M.
  - Register effects are visible from the following cycle.
  - mfc0 reads the register value before the edge; there is no same-cycle mtc0→mfc0 bypass.
- Pending interrupt: taken at the first valid M cycle after the bubble(s), with one cycle of req.
- Reset asserted mid-handler (EXL=1) clears EXL immediately; no req is generated during reset.

## Test plan
- Syscall: SR=32'h0000_0401, valid_m=1, pc_m=32'h0000_3008, exc_code_m=8 -> req=1 same cycle; next cycle EPC=32'h0000_3008, Cause.ExcCode=8, EXL=1, exl_out=1.
- Delay-slot trap: bd_m=1, pc_m=32'h0000_3010, exc_code_m=13 -> EPC=32'h0000_300C, Cause.BD=1; a second exc_code_m=9 while EXL=1 -> req=0, no state change.
- Interrupt priority: SR=32'h0000_0401, hw_int=6'b000001, exc_code_m=9 in the same cycle -> req=1, Cause.ExcCode=0, Cause.IP=6'b000001.
- Pending across bubble: hw_int pulses for one cycle while valid_m=0, then drops; valid_m=1 two cycles later with pc_m=32'h0000_3020 -> req=1 in that cycle, EPC=32'h0000_3020.
- eret/mtc0 ordering: mtc0 EPC←32'h0000_3044, then eret next cycle -> epc_out=32'h0000_3044 during eret, EXL=0 afterwards; mtc0 coincident with req is dropped.
- Async reset with EXL=1 and EPC=32'h0000_3000 -> all outputs 0 before the next clk edge; PRId read returns 32'h2023_0007.
